// File: rtl/screen_scanner.sv
// screen_scanner
// Raster-scans a flattened 24-bit RGB framebuffer and streams one pixel
// per valid/ready transfer, tagged with coordinates and frame markers.
// A blanking gap of BLANK_CYCLES idle cycles separates frames, and a
// modulo-256 counter tracks completed frames.
//
// Optional feature macro: SCANNER_SNAPSHOT_EN
//   defined   -> the whole framebuffer is registered at frame start, so
//                every pixel of a frame comes from one snapshot (tear-free)
//   undefined -> each pixel is fetched from the live framebuffer when the
//                coordinate advances (a frame may mix game states)
//
// Ports:
//   clk          in   clock, rising-edge active
//   reset        in   asynchronous active-high reset
//   screen       in   framebuffer, pixel p = y*SCR_W+x at bits [24p+23:24p]
//   enable       in   scanning permitted (sampled in IDLE and at end of BLANK)
//   pix_ready    in   sink accepts current pixel
//   pix_valid    out  current pixel valid
//   pix_data     out  RGB of current pixel
//   pix_x/pix_y  out  coordinates of current pixel
//   sof/eol/eof  out  start-of-frame, end-of-line, end-of-frame markers
//   frame_count  out  completed frames modulo 256
module screen_scanner #(
    parameter int SCR_W        = 30,
    parameter int SCR_H        = 30,
    parameter int BLANK_CYCLES = 4,
    parameter int XW           = $clog2(SCR_W),
    parameter int YW           = $clog2(SCR_H)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [24*SCR_W*SCR_H-1:0] screen,
    input  logic                      enable,
    input  logic                      pix_ready,
    output logic                      pix_valid,
    output logic [23:0]               pix_data,
    output logic [XW-1:0]             pix_x,
    output logic [YW-1:0]             pix_y,
    output logic                      sof,
    output logic                      eol,
    output logic                      eof,
    output logic [7:0]                frame_count
);

    localparam int NPIX = SCR_W * SCR_H;
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [XW-1:0] X_LAST     = XW'(SCR_W - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(SCR_H - 1);
    localparam logic [7:0]    BLANK_LOAD = 8'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        BLANK
    } state_t;

    state_t              state;
    logic [7:0]          blank_cnt;
    logic [IW-1:0]       pix_idx;

    logic [XW-1:0]       next_x;
    logic [YW-1:0]       next_y;
    logic [IW-1:0]       next_idx;
    logic                next_eol;
    logic                next_eof;
    logic                start;
    logic [24*NPIX-1:0]  frame_src;

    // A new frame begins from IDLE, or straight out of the last blanking
    // cycle, whenever enable is high at that edge.
    assign start = enable &&
                   ((state == IDLE) || ((state == BLANK) && (blank_cnt == 8'd1)));

    // The linear pixel index runs alongside (x,y) so the framebuffer slice
    // can be addressed without a multiplier.
    always_comb begin
        next_x   = '0;
        next_y   = pix_y;
        next_idx = pix_idx + IW'(1);
        if (pix_x == X_LAST) begin
            next_x = '0;
            next_y = pix_y + YW'(1);
        end else begin
            next_x = pix_x + XW'(1);
        end
        next_eol = (next_x == X_LAST);
        next_eof = next_eol && (next_y == Y_LAST);
    end

`ifdef SCANNER_SNAPSHOT_EN
    logic [24*NPIX-1:0] snap;

    // Frame copy taken on the start edge; all later pixels of the frame
    // are read from it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap <= '0;
        end else if (start) begin
            snap <= screen;
        end
    end

    assign frame_src = snap;
`else
    assign frame_src = screen;
`endif

    // Main scan FSM. Outputs change only on the start edge or on a
    // transfer edge, which keeps them stable through sink stalls. After
    // the eof transfer the coordinate registers are left as they are;
    // they are meaningless while pix_valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            blank_cnt   <= '0;
            pix_idx     <= '0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            eof         <= 1'b0;
            frame_count <= '0;
        end else if (start) begin
            state     <= STREAM;
            blank_cnt <= '0;
            pix_idx   <= '0;
            pix_valid <= 1'b1;
            pix_data  <= screen[23:0];
            pix_x     <= '0;
            pix_y     <= '0;
            sof       <= 1'b1;
            eol       <= (SCR_W == 1);
            eof       <= (NPIX == 1);
        end else begin
            case (state)
                STREAM: begin
                    if (pix_ready) begin
                        if (eof) begin
                            state       <= BLANK;
                            pix_valid   <= 1'b0;
                            blank_cnt   <= BLANK_LOAD;
                            frame_count <= frame_count + 8'd1;
                        end else begin
                            pix_idx  <= next_idx;
                            pix_x    <= next_x;
                            pix_y    <= next_y;
                            sof      <= 1'b0;
                            eol      <= next_eol;
                            eof      <= next_eof;
                            pix_data <= frame_src[24*next_idx +: 24];
                        end
                    end
                end
                BLANK: begin
                    // Reaching 1 with enable low parks the block in IDLE;
                    // the enable-high case is taken by the start branch.
                    if (blank_cnt == 8'd1) begin
                        state     <= IDLE;
                        blank_cnt <= '0;
                    end else begin
                        blank_cnt <= blank_cnt - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_scanner.sv
// tb_screen_scanner
// Directed self-checking bench for screen_scanner on a 4x4 screen with a
// 4-cycle blanking gap. Pixel p of the framebuffer holds {p, ~p, 8'h5A}.
// Expected pixel contents follow SCANNER_SNAPSHOT_EN when it is defined.
module tb_screen_scanner;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int NPIX  = W * H;
    localparam int BLANK = 4;

    logic                 clk;
    logic                 reset;
    logic [24*NPIX-1:0]   screen;
    logic                 enable;
    logic                 pix_ready;
    logic                 pix_valid;
    logic [23:0]          pix_data;
    logic [1:0]           pix_x;
    logic [1:0]           pix_y;
    logic                 sof;
    logic                 eol;
    logic                 eof;
    logic [7:0]           frame_count;

    logic [24*NPIX-1:0]   golden_screen;
    logic [3:0]           ready_pat;
    int                   vectors;
    int                   miscompares;
    int                   corrupt_from;
    int                   slots;

    screen_scanner #(
        .SCR_W        (W),
        .SCR_H        (H),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .screen      (screen),
        .enable      (enable),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .sof         (sof),
        .eol         (eol),
        .eof         (eof),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [23:0] expPix(input int p);
        logic [7:0] b;
        if (p >= corrupt_from) begin
            return 24'hFFFFFF;
        end
        b = 8'(p);
        return {b, ~b, 8'h5A};
    endfunction

    task automatic applyStimulus(input logic en, input logic rdy);
        enable    = en;
        pix_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkPixel(input string tag, input int p);
        int x;
        int y;
        x = p % W;
        y = p / W;
        checkOutput($sformatf("%s_p%0d_valid", tag, p), 32'(pix_valid), 32'd1);
        checkOutput($sformatf("%s_p%0d_data", tag, p), 32'(pix_data), 32'(expPix(p)));
        checkOutput($sformatf("%s_p%0d_x", tag, p), 32'(pix_x), 32'(x));
        checkOutput($sformatf("%s_p%0d_y", tag, p), 32'(pix_y), 32'(y));
        checkOutput($sformatf("%s_p%0d_sof", tag, p), 32'(sof), 32'(p == 0));
        checkOutput($sformatf("%s_p%0d_eol", tag, p), 32'(eol), 32'(x == W - 1));
        checkOutput($sformatf("%s_p%0d_eof", tag, p), 32'(eof), 32'(p == NPIX - 1));
    endtask

    task automatic checkIdleZero(input string tag, input logic [7:0] fc);
        checkOutput({tag, "_valid"}, 32'(pix_valid), 32'd0);
        checkOutput({tag, "_data"}, 32'(pix_data), 32'd0);
        checkOutput({tag, "_x"}, 32'(pix_x), 32'd0);
        checkOutput({tag, "_y"}, 32'(pix_y), 32'd0);
        checkOutput({tag, "_sof"}, 32'(sof), 32'd0);
        checkOutput({tag, "_eol"}, 32'(eol), 32'd0);
        checkOutput({tag, "_eof"}, 32'(eof), 32'd0);
        checkOutput({tag, "_fc"}, 32'(frame_count), 32'(fc));
    endtask

    // Entered at a falling edge with pixel 0 presented. mode 0: ready held
    // high; mode 1: ready follows 1,0,0,1; mode 2: ready high, screen forced
    // to white while pixel 5 is shown, enable dropped while pixel 8 is shown.
    task automatic runFrame(input int mode, input string tag, output int used);
        int   p;
        int   slot;
        logic xfer;
        p    = 0;
        slot = 0;
        while (p < NPIX && slot < 200) begin
            checkPixel(tag, p);
            if (mode == 1) begin
                pix_ready = ready_pat[slot % 4];
            end else begin
                pix_ready = 1'b1;
            end
            if (mode == 2 && p == 5) begin
                screen = '1;
            end
            if (mode == 2 && p == 8) begin
                enable = 1'b0;
            end
            xfer = pix_ready;
            @(negedge clk);
            if (xfer) begin
                p++;
            end
            slot++;
        end
        used = slot;
    endtask

    task automatic checkBlank(input string tag, input logic [7:0] fc);
        for (int i = 0; i < BLANK; i++) begin
            checkOutput($sformatf("%s_blank%0d_valid", tag, i), 32'(pix_valid), 32'd0);
            checkOutput($sformatf("%s_blank%0d_fc", tag, i), 32'(frame_count), 32'(fc));
            pix_ready = i[0];
            @(negedge clk);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        corrupt_from = 1000;
        ready_pat    = 4'b1001;
        for (int p = 0; p < NPIX; p++) begin
            golden_screen[24*p +: 24] = expPix(p);
        end
        screen = golden_screen;
        reset  = 1'b1;
        applyStimulus(1'b0, 1'b0);

        // Reset held, then 20 cycles with enable low.
        @(negedge clk);
        checkIdleZero("reset_hold", 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pix_ready = i[1];
            @(negedge clk);
            checkOutput($sformatf("idle_c%0d_valid", i), 32'(pix_valid), 32'd0);
        end
        checkIdleZero("idle_end", 8'd0);

        // Frame 1: ready always high, 16 pixels then 4 blank cycles.
        $display("[TB] frame 1: continuous ready");
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        runFrame(0, "f1", slots);
        checkOutput("f1_slots", 32'(slots), 32'd16);
        checkBlank("f1", 8'd1);

        // Frame 2 starts right after blanking; ready pattern 1,0,0,1.
        $display("[TB] frame 2: stalling ready pattern");
        runFrame(1, "f2", slots);
        checkOutput("f2_slots", 32'(slots), 32'd32);
        checkBlank("f2", 8'd2);

        // Frame 3: screen overwritten at pixel 5, enable dropped at pixel 8.
        $display("[TB] frame 3: screen change and enable drop");
        pix_ready = 1'b1;
`ifndef SCANNER_SNAPSHOT_EN
        corrupt_from = 6;
`endif
        runFrame(2, "f3", slots);
        checkOutput("f3_slots", 32'(slots), 32'd16);
        screen       = golden_screen;
        corrupt_from = 1000;
        checkBlank("f3", 8'd3);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("parked_c%0d_valid", i), 32'(pix_valid), 32'd0);
            checkOutput($sformatf("parked_c%0d_fc", i), 32'(frame_count), 32'd3);
            @(negedge clk);
        end

        // Frame 4: reset asserted asynchronously while pixel 10 is shown.
        $display("[TB] frame 4: async reset mid-frame");
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        for (int p = 0; p < 10; p++) begin
            checkPixel("f4", p);
            @(negedge clk);
        end
        checkPixel("f4", 10);
        #2;
        reset = 1'b1;
        #1;
        checkIdleZero("async_reset", 8'd0);
        @(negedge clk);
        checkIdleZero("reset_held", 8'd0);
        reset = 1'b0;
        @(negedge clk);
        checkPixel("restart", 0);
        @(negedge clk);
        checkPixel("restart", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
